// File: rtl/sparc_ifu_lfsr_nch_if.sv
// Request/response bundle for the per-thread LFSR way picker.
// Parameters must match those of the sparc_ifu_lfsr_nch instance using it.
interface sparc_ifu_lfsr_nch_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned NCH   = 4,
    parameter int unsigned OUTW  = 2
);
    localparam int unsigned NW  = 1 << OUTW;
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   advance;
    logic [NCH-1:0]   load;
    logic [WIDTH-1:0] seed;
    logic             pick_req;
    logic [CHW-1:0]   pick_ch;
    logic [NW-1:0]    way_vld;
    logic             pick_vld;
    logic [OUTW-1:0]  pick_way;
    logic             pick_rnd;
    logic [NCH-1:0]   lockup;

    modport master (
        output advance, load, seed, pick_req, pick_ch, way_vld,
        input  pick_vld, pick_way, pick_rnd, lockup
    );

    modport slave (
        input  advance, load, seed, pick_req, pick_ch, way_vld,
        output pick_vld, pick_way, pick_rnd, lockup
    );
endinterface

// File: rtl/sparc_ifu_lfsr_nch.sv
// NCH independent Fibonacci LFSRs with all-zero lock-up recovery, plus a
// registered way picker: first invalid way if any, else low LFSR bits.
module sparc_ifu_lfsr_nch #(
    parameter int unsigned      WIDTH    = 5,
    parameter logic [WIDTH-1:0] TAPS     = 5'b10010,
    parameter int unsigned      NCH      = 4,
    parameter int unsigned      OUTW     = 2,
    parameter logic [WIDTH-1:0] RST_SEED = '1
) (
    input logic                 clk,
    input logic                 reset,
    sparc_ifu_lfsr_nch_if.slave bus
);
    localparam int unsigned NW = 1 << OUTW;

    logic [WIDTH-1:0] q     [NCH];
    logic [WIDTH-1:0] q_nxt [NCH];
    logic [NCH-1:0]   step;
    logic [NCH-1:0]   recov;
    logic [NCH-1:0]   lockup_q;

    logic             ch_ok;
    logic             all_vld;
    logic [OUTW-1:0]  q_sel;
    logic [OUTW-1:0]  hole_way;
    logic [OUTW-1:0]  way_nxt;
    logic             rnd_nxt;

    logic             pick_vld_q;
    logic [OUTW-1:0]  pick_way_q;
    logic             pick_rnd_q;

    // Pick decode: out-of-range channel gives way 0 and never steps anything.
    always_comb begin
        ch_ok    = 32'(bus.pick_ch) < NCH;
        all_vld  = &bus.way_vld;
        q_sel    = '0;
        hole_way = '0;
        way_nxt  = '0;
        rnd_nxt  = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (32'(bus.pick_ch) == c) q_sel = q[c][OUTW-1:0];
        end
        // Scan downward so the lowest invalid index wins.
        for (int unsigned i = NW; i > 0; i--) begin
            if (!bus.way_vld[i-1]) hole_way = OUTW'(i - 1);
        end
        if (!ch_ok) begin
            way_nxt = '0;
            rnd_nxt = 1'b0;
        end else if (all_vld) begin
            way_nxt = q_sel;
            rnd_nxt = 1'b1;
        end else begin
            way_nxt = hole_way;
            rnd_nxt = 1'b0;
        end
    end

    // Per-channel next state: load > lock-up recovery > step > hold.
    always_comb begin
        step  = '0;
        recov = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            q_nxt[c] = q[c];
            step[c]  = bus.advance[c]
                     | (bus.pick_req & ch_ok & all_vld & (32'(bus.pick_ch) == c));
            recov[c] = ~bus.load[c] & (q[c] == '0);
            if (bus.load[c]) begin
                q_nxt[c] = bus.seed;
            end else if (q[c] == '0) begin
                q_nxt[c] = RST_SEED;
            end else if (step[c]) begin
                q_nxt[c] = {q[c][WIDTH-2:0], ^(q[c] & TAPS)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) q[c] <= RST_SEED;
            lockup_q   <= '0;
            pick_vld_q <= 1'b0;
            pick_way_q <= '0;
            pick_rnd_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) q[c] <= q_nxt[c];
            lockup_q   <= recov;
            pick_vld_q <= bus.pick_req;
            if (bus.pick_req) begin
                pick_way_q <= way_nxt;
                pick_rnd_q <= rnd_nxt;
            end
        end
    end

    assign bus.pick_vld = pick_vld_q;
    assign bus.pick_way = pick_way_q;
    assign bus.pick_rnd = pick_rnd_q;
    assign bus.lockup   = lockup_q;
endmodule

// File: tb/tb_sparc_ifu_lfsr_nch.sv
// Directed bench for sparc_ifu_lfsr_nch: pick results go through a scoreboard
// queue; LFSR state is observed hierarchically against spec-derived values.
module tb_sparc_ifu_lfsr_nch;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sparc_ifu_lfsr_nch_if #(.WIDTH(5), .NCH(4), .OUTW(2)) bus ();
    sparc_ifu_lfsr_nch_if #(.WIDTH(5), .NCH(3), .OUTW(2)) bus3 ();

    sparc_ifu_lfsr_nch #(
        .WIDTH(5), .TAPS(5'b10010), .NCH(4), .OUTW(2), .RST_SEED(5'b11111)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    sparc_ifu_lfsr_nch #(
        .WIDTH(5), .TAPS(5'b10010), .NCH(3), .OUTW(2), .RST_SEED(5'b11111)
    ) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct packed {
        logic [1:0] way;
        logic       rnd;
    } pick_t;

    pick_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pick(input logic [1:0] w, input logic r);
        sb.push_back({w, r});
    endtask

    // One clock; then compare the pick output against the scoreboard.
    task automatic cyc(input string tag);
        pick_t p;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            chk({tag, ".vld"}, 32'(bus.pick_vld), 32'd1);
            chk({tag, ".way"}, 32'(bus.pick_way), 32'(p.way));
            chk({tag, ".rnd"}, 32'(bus.pick_rnd), 32'(p.rnd));
        end else begin
            chk({tag, ".idle"}, 32'(bus.pick_vld), 32'd0);
        end
    endtask

    function automatic logic [4:0] lfsr5(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[1]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] seq [4];
        logic [4:0] m;
        seq[0] = 5'b11110; seq[1] = 5'b11100; seq[2] = 5'b11001; seq[3] = 5'b10011;

        reset = 1'b1;
        bus.advance = '0; bus.load = '0; bus.seed = '0;
        bus.pick_req = 1'b0; bus.pick_ch = '0; bus.way_vld = '0;
        bus3.advance = '0; bus3.load = '0; bus3.seed = '0;
        bus3.pick_req = 1'b0; bus3.pick_ch = '0; bus3.way_vld = '0;
        cyc("rst0");
        cyc("rst1");
        reset = 1'b0;
        chk("rst.way", 32'(bus.pick_way), 32'd0);
        chk("rst.rnd", 32'(bus.pick_rnd), 32'd0);
        chk("rst.lockup", 32'(bus.lockup), 32'd0);
        for (int c = 0; c < 4; c++) chk("rst.q", 32'(dut.q[c]), 32'h1f);

        // Four steps on channel 0 only.
        bus.advance = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            cyc("adv0");
            chk("adv0.q0", 32'(dut.q[0]), 32'(seq[k]));
            for (int c = 1; c < 4; c++) chk("adv0.other", 32'(dut.q[c]), 32'h1f);
        end

        // Full period on channel 1.
        bus.advance = 4'b0010;
        m = 5'h1f;
        for (int k = 0; k < 31; k++) begin
            cyc("per");
            m = lfsr5(m);
            chk("per.q1", 32'(dut.q[1]), 32'(m));
            chk("per.at_seed", 32'(dut.q[1] == 5'h1f), 32'(k == 30));
            chk("per.lockup", 32'(bus.lockup), 32'd0);
        end
        bus.advance = '0;

        reset = 1'b1;
        cyc("rst2");
        reset = 1'b0;

        // Back-to-back random picks on channel 2, then hold while idle.
        bus.pick_req = 1'b1; bus.pick_ch = 2'd2; bus.way_vld = 4'b1111;
        expect_pick(2'd3, 1'b1);
        cyc("rnd0");
        expect_pick(2'd2, 1'b1);
        cyc("rnd1");
        bus.pick_req = 1'b0;
        cyc("hold");
        chk("hold.way", 32'(bus.pick_way), 32'd2);
        chk("hold.rnd", 32'(bus.pick_rnd), 32'd1);
        chk("rnd.q2", 32'(dut.q[2]), 32'h1c);
        chk("rnd.q0", 32'(dut.q[0]), 32'h1f);

        // Invalid-way picks: lowest hole, no auto-advance.
        bus.pick_req = 1'b1; bus.pick_ch = 2'd0; bus.way_vld = 4'b1011;
        expect_pick(2'd2, 1'b0);
        cyc("hole2");
        bus.pick_ch = 2'd1; bus.way_vld = 4'b0111;
        expect_pick(2'd3, 1'b0);
        cyc("hole3");
        bus.way_vld = 4'b0000;
        expect_pick(2'd0, 1'b0);
        cyc("hole0");
        chk("hole.q0", 32'(dut.q[0]), 32'h1f);
        chk("hole.q1", 32'(dut.q[1]), 32'h1f);

        // advance and auto-advance together give a single step.
        bus.pick_ch = 2'd3; bus.way_vld = 4'b1111; bus.advance = 4'b1000;
        expect_pick(2'd3, 1'b1);
        cyc("dual");
        bus.pick_req = 1'b0; bus.advance = '0;
        chk("dual.q3", 32'(dut.q[3]), 32'h1e);

        // Zero seed on channel 3: store, recover, then one lockup pulse.
        bus.load = 4'b1000; bus.seed = 5'b00000;
        cyc("ld0");
        bus.load = '0;
        chk("ld0.q3", 32'(dut.q[3]), 32'h00);
        chk("ld0.lockup", 32'(bus.lockup), 32'd0);
        cyc("rec");
        chk("rec.q3", 32'(dut.q[3]), 32'h1f);
        chk("rec.lockup", 32'(bus.lockup), 32'h8);
        chk("rec.q2", 32'(dut.q[2]), 32'h1c);
        cyc("rec2");
        chk("rec2.lockup", 32'(bus.lockup), 32'd0);
        chk("rec2.q3", 32'(dut.q[3]), 32'h1f);

        // Recovery wins over a pending step.
        bus.load = 4'b0001; bus.advance = 4'b0001;
        cyc("ldstep");
        bus.load = '0;
        chk("ldstep.q0", 32'(dut.q[0]), 32'h00);
        cyc("recstep");
        chk("recstep.q0", 32'(dut.q[0]), 32'h1f);
        chk("recstep.lockup", 32'(bus.lockup), 32'h1);
        cyc("poststep");
        bus.advance = '0;
        chk("poststep.q0", 32'(dut.q[0]), 32'h1e);
        chk("poststep.lockup", 32'(bus.lockup), 32'd0);

        // Reset overrides load and drops the pick.
        reset = 1'b1; bus.load = 4'b0001; bus.seed = 5'b00101; bus.pick_req = 1'b1;
        cyc("rstov");
        reset = 1'b0; bus.load = '0; bus.pick_req = 1'b0;
        chk("rstov.q0", 32'(dut.q[0]), 32'h1f);
        chk("rstov.lockup", 32'(bus.lockup), 32'd0);

        // Out-of-range channel on the three-channel instance.
        bus3.pick_req = 1'b1; bus3.pick_ch = 2'd1; bus3.way_vld = 4'b1011;
        @(posedge clk); #1;
        chk("oor.pre_way", 32'(bus3.pick_way), 32'd2);
        bus3.pick_ch = 2'd3; bus3.way_vld = 4'b1111;
        @(posedge clk); #1;
        bus3.pick_req = 1'b0;
        chk("oor.vld", 32'(bus3.pick_vld), 32'd1);
        chk("oor.way", 32'(bus3.pick_way), 32'd0);
        chk("oor.rnd", 32'(bus3.pick_rnd), 32'd0);
        for (int c = 0; c < 3; c++) chk("oor.q", 32'(dut3.q[c]), 32'h1f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sparc_ifu_lfsr_nch.md
SPARC_IFU_LFSR_NCH -- requirements
Module: sparc_ifu_lfsr_nch

Interface
REQ-001 SHALL have parameter WIDTH, default 5, LFSR state width per channel (legal 3..16).
REQ-002 SHALL have parameter TAPS, default 5'b10010, WIDTH-bit feedback mask; feedback bit = XOR of q[i] for every i where TAPS[i]=1.
REQ-003 SHALL have parameter NCH, default 4, number of independent LFSR channels (legal 1..8).
REQ-004 SHALL have parameter OUTW, default 2, way-index width (legal 1..WIDTH); way count NW = 2^OUTW.
REQ-005 SHALL have parameter RST_SEED, default all-ones (WIDTH bits), reset and lock-up recovery value.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port advance, input, NCH, per-channel step request.
REQ-009 SHALL have port load, input, NCH, per-channel seed load.
REQ-010 SHALL have port seed, input, WIDTH, seed value shared by all channels.
REQ-011 SHALL have port pick_req, input, 1, way-pick request.
REQ-012 SHALL have port pick_ch, input, clog2(NCH) (min 1), channel for pick.
REQ-013 SHALL have port way_vld, input, NW, per-way valid mask for pick.
REQ-014 SHALL have port pick_vld, output, 1, pick result valid.
REQ-015 SHALL have port pick_way, output, OUTW, selected way.
REQ-016 SHALL have port pick_rnd, output, 1, result came from the LFSR (all ways valid).
REQ-017 SHALL have port lockup, output, NCH, per-channel all-zero recovery pulse.

Function
REQ-018 Each channel SHALL hold a WIDTH-bit register q; a step SHALL compute q_next = {q[WIDTH-2:0], fb}.
REQ-019 Per-channel next-state priority SHALL be: reset -> RST_SEED; load -> seed; q==0 -> RST_SEED (recovery); step -> shifted value; else hold.
REQ-020 A channel SHALL step when advance[c]=1, or when pick_req=1, pick_ch=c and way_vld is all ones (auto-advance); both in one cycle SHALL produce exactly one step.
REQ-021 Recovery SHALL occur whenever q==0 without load/reset, whether or not a step is requested; lockup[c] SHALL be registered and pulse 1 for exactly the cycle after each recovery.
REQ-022 load with seed==0 SHALL store 0; recovery follows next cycle, with lockup pulse the cycle after that.
REQ-023 Pick latency SHALL be one cycle: pick_vld=1 in cycle N+1 iff pick_req=1 in cycle N; pick_req is accepted every cycle (back-to-back, no stall).
REQ-024 If any way_vld bit is 0 in cycle N, pick_way SHALL be the lowest index i with way_vld[i]=0 and pick_rnd=0, and the channel SHALL not auto-advance.
REQ-025 If way_vld is all ones, pick_way SHALL equal q[pick_ch][OUTW-1:0] as held in cycle N (pre-update value), with pick_rnd=1.
REQ-026 pick_ch >= NCH SHALL yield pick_vld=1, pick_way=0, pick_rnd=0, and SHALL advance no channel.
REQ-027 pick_way and pick_rnd SHALL hold their last value while pick_vld=0.
REQ-028 Channels SHALL be fully independent; a load or step of one channel SHALL not alter another.

Reset
REQ-029 On reset every q SHALL become RST_SEED; pick_vld, pick_way, pick_rnd and lockup SHALL be 0 the following cycle.
REQ-030 Reset SHALL override load, advance and pick_req in the same cycle; a pick issued the cycle reset asserts SHALL be dropped (no pick_vld).

Verification
REQ-031 Defaults, after reset, advance[0]=1 for 4 cycles -> q0 sequence 11111, 11110, 11100, 11001, 10011; other channels stay 11111.
REQ-032 Defaults, advance[1] held 31 cycles from 11111 -> q1 returns to 11111 with no earlier repeat and no lockup pulse (period 31).
REQ-033 After reset, pick_req=1, pick_ch=2, way_vld=4'b1111 for 2 consecutive cycles -> pick_way 3 then 2, pick_rnd=1 both cycles, q2=11100 afterwards.
REQ-034 pick_req=1, pick_ch=0, way_vld=4'b1011 -> next cycle pick_way=2, pick_rnd=0, q0 unchanged.
REQ-035 load[3]=1, seed=00000 -> q3=0 the next cycle, 11111 the cycle after, lockup[3]=1 for one cycle thereafter only.
REQ-036 reset asserted with load[0]=1, seed=00101, pick_req=1 -> q0=11111, pick_vld=0 the next cycle.
